// File: rtl/mc_lc_ctrl_if.sv
// Handshake bundle between the mc_lc sequencing controller, the mc_lc datapath
// and the downstream transform stage.
interface mc_lc_ctrl_if #(
   parameter int BLKS_X = 4,
   parameter int BLKS_Y = 4
);
   localparam int NBLK = BLKS_X * BLKS_Y;
   localparam int XW   = $clog2(BLKS_X);
   localparam int YW   = $clog2(BLKS_Y);
   localparam int IW   = $clog2(NBLK);

   logic [XW-1:0] blk_x;
   logic [YW-1:0] blk_y;
   logic          dp_src_valid;
   logic          dp_src_ready;
   logic          dp_dst_valid;
   logic          dp_dst_ready;
   logic          out_valid;
   logic          out_ready;
   logic [IW-1:0] out_blk_idx;

   modport master (
      output blk_x, blk_y, dp_src_valid, dp_dst_ready, out_valid, out_blk_idx,
      input  dp_src_ready, dp_dst_valid, out_ready
   );

   modport slave (
      input  blk_x, blk_y, dp_src_valid, dp_dst_ready, out_valid, out_blk_idx,
      output dp_src_ready, dp_dst_valid, out_ready
   );
endinterface

// File: rtl/mc_lc_ctrl.sv
// Walks one macroblock's sub-blocks through mc_lc in raster order, limiting the
// number in flight and forwarding residual beats downstream with backpressure.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   ST_IDLE | waiting for mb_start, counters cleared
//   ST_RUN  | issuing sub-blocks and forwarding their residuals
//   ST_DONE | single-cycle mb_done pulse, counters clear on exit
module mc_lc_ctrl #(
   parameter int MB_SIZE      = 4,
   parameter int BLKS_X       = 4,
   parameter int BLKS_Y       = 4,
   parameter int MAX_INFLIGHT = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         mb_start,
   output logic         mb_busy,
   output logic         mb_done,
   output logic         err,
   mc_lc_ctrl_if.master bus
);
   localparam int NBLK = BLKS_X * BLKS_Y;
   localparam int XW   = $clog2(BLKS_X);
   localparam int YW   = $clog2(BLKS_Y);
   localparam int IW   = $clog2(NBLK);
   localparam int CW   = IW + 1;

   localparam logic [CW-1:0] CNT_FULL  = CW'(NBLK);
   localparam logic [CW-1:0] CNT_LAST  = CW'(NBLK - 1);
   localparam logic [CW-1:0] CNT_LIMIT = CW'(MAX_INFLIGHT);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);

   if (MB_SIZE < 1 || MAX_INFLIGHT < 1 || MAX_INFLIGHT > NBLK || YW < 1) begin : g_bad_param
      $error("mc_lc_ctrl: parameter out of range");
   end

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] iss_q, iss_d;
   logic [CW-1:0] ret_q, ret_d;
   logic [CW-1:0] inflight;
   logic          err_q, err_d;
   logic          spurious;
   logic          issue, retire;

   logic          src_valid;
   logic          dst_ready;
   logic          fwd_valid;
   logic [IW-1:0] fwd_idx;
   logic [XW-1:0] cur_x;
   logic [YW-1:0] cur_y;

   assign inflight = iss_q - ret_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         iss_q   <= '0;
         ret_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         iss_q   <= iss_d;
         ret_q   <= ret_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      iss_d     = iss_q;
      ret_d     = ret_q;
      err_d     = err_q;
      mb_busy   = 1'b0;
      mb_done   = 1'b0;
      src_valid = 1'b0;
      dst_ready = 1'b0;
      fwd_valid = 1'b0;
      fwd_idx   = '0;
      cur_x     = '0;
      cur_y     = '0;
      issue     = 1'b0;
      retire    = 1'b0;

      // A return with nothing outstanding is a datapath protocol violation.
      spurious = bus.dp_dst_valid && (inflight == '0);
      if (spurious) err_d = 1'b1;

      unique case (state_q)
         ST_IDLE: begin
            if (mb_start) state_d = ST_RUN;
         end
         ST_RUN: begin
            mb_busy   = 1'b1;
            src_valid = (iss_q < CNT_FULL) && (inflight < CNT_LIMIT);
            cur_x     = iss_q[XW-1:0];
            cur_y     = iss_q[IW-1:XW];
            dst_ready = bus.out_ready;
            fwd_valid = bus.dp_dst_valid && !spurious;
            fwd_idx   = ret_q[IW-1:0];
            issue     = src_valid && bus.dp_src_ready;
            retire    = fwd_valid && bus.out_ready;
            if (issue)  iss_d = iss_q + CNT_ONE;
            if (retire) ret_d = ret_q + CNT_ONE;
            if (retire && (ret_q == CNT_LAST)) state_d = ST_DONE;
         end
         ST_DONE: begin
            mb_busy = 1'b1;
            mb_done = 1'b1;
            state_d = ST_IDLE;
            iss_d   = '0;
            ret_d   = '0;
         end
         default: begin
            state_d = ST_IDLE;
            iss_d   = '0;
            ret_d   = '0;
         end
      endcase
   end

   assign err              = err_q;
   assign bus.dp_src_valid = src_valid;
   assign bus.dp_dst_ready = dst_ready;
   assign bus.out_valid    = fwd_valid;
   assign bus.out_blk_idx  = fwd_idx;
   assign bus.blk_x        = cur_x;
   assign bus.blk_y        = cur_y;
endmodule

// File: tb/tb_mc_lc_ctrl.sv
// Randomised bench for mc_lc_ctrl against a queue-based model of issued and
// returned sub-blocks.
module tb_mc_lc_ctrl;
   logic clk = 1'b0;
   logic reset;
   logic mb_start;
   logic mb_busy;
   logic mb_done;
   logic err;

   always #5 clk = ~clk;

   mc_lc_ctrl_if #(.BLKS_X(4), .BLKS_Y(4)) bus ();

   mc_lc_ctrl #(
      .MB_SIZE(4), .BLKS_X(4), .BLKS_Y(4), .MAX_INFLIGHT(2)
   ) dut (
      .clk(clk),
      .reset(reset),
      .mb_start(mb_start),
      .mb_busy(mb_busy),
      .mb_done(mb_done),
      .err(err),
      .bus(bus.master)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // model: phase 0 idle, 1 running, 2 done pulse
   int phase = 0;
   int n_iss = 0;
   int n_ret = 0;
   int q_blk[$];
   bit m_err = 1'b0;
   bit checking = 1'b0;
   int done_seen = 0;
   int beats_seen = 0;

   int p_src = 100, p_dst = 100, p_out = 100;
   bit ign_start = 1'b0;
   bit hold_out_low = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
      end
   endtask

   function automatic bit roll(input int p);
      return ($urandom_range(99, 0) < p);
   endfunction

   task automatic drive();
      bus.dp_src_ready = roll(p_src);
      bus.out_ready    = hold_out_low ? 1'b0 : roll(p_out);
      bus.dp_dst_valid = (q_blk.size() > 0) ? roll(p_dst) : 1'b0;
      mb_start         = ign_start && (phase != 0);
   endtask

   task automatic step();
      bit e_src, e_ov, iss, ret, s_dv, s_start, s_reset;
      int e_idx;
      @(negedge clk);
      e_src = (phase == 1) && (n_iss < 16) && (q_blk.size() < 2);
      e_ov  = (phase == 1) && (bus.dp_dst_valid === 1'b1) && (q_blk.size() > 0);
      e_idx = (phase != 1) ? 0 : ((q_blk.size() > 0) ? q_blk[0] : n_ret % 16);
      if (checking) begin
         chk("mb_busy",     mb_busy,          phase != 0);
         chk("mb_done",     mb_done,          phase == 2);
         chk("err",         err,              m_err);
         chk("src_valid",   bus.dp_src_valid, e_src);
         chk("blk_x",       bus.blk_x,        (phase == 1) ? n_iss % 4 : 0);
         chk("blk_y",       bus.blk_y,        (phase == 1) ? (n_iss / 4) % 4 : 0);
         chk("dst_ready",   bus.dp_dst_ready, (phase == 1) && (bus.out_ready === 1'b1));
         chk("out_valid",   bus.out_valid,    e_ov);
         chk("out_blk_idx", bus.out_blk_idx,  e_idx);
      end
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) beats_seen++;
      if (mb_done === 1'b1) done_seen++;
      iss     = e_src && bus.dp_src_ready;
      ret     = e_ov && bus.out_ready;
      s_dv    = bus.dp_dst_valid;
      s_start = mb_start;
      s_reset = reset;
      @(posedge clk);
      if (s_reset) begin
         phase = 0; n_iss = 0; n_ret = 0; q_blk.delete(); m_err = 1'b0;
      end else begin
         if (s_dv && q_blk.size() == 0) m_err = 1'b1;
         case (phase)
            0: if (s_start) phase = 1;
            1: begin
               if (ret) begin
                  void'(q_blk.pop_front());
                  n_ret++;
               end
               if (iss) begin
                  q_blk.push_back(n_iss);
                  n_iss++;
               end
               if (ret && n_ret == 16) phase = 2;
            end
            default: begin
               phase = 0; n_iss = 0; n_ret = 0;
            end
         endcase
      end
      #1;
   endtask

   task automatic run_mb(input int bp_at, input int budget);
      int cyc = 0;
      int done0 = done_seen;
      int beats0 = beats_seen;
      drive();
      mb_start = 1'b1;
      step();
      while (phase != 0 && cyc < budget) begin
         hold_out_low = (bp_at >= 0) && (cyc >= bp_at) && (cyc < bp_at + 20);
         drive();
         step();
         if (bp_at >= 0 && cyc == bp_at + 19) chk("bp_src_valid_capped", bus.dp_src_valid, 1'b0);
         cyc++;
      end
      hold_out_low = 1'b0;
      chk("mb_timeout", cyc < budget, 1'b1);
      chk("beats_per_mb", beats_seen - beats0, 16);
      chk("done_per_mb", done_seen - done0, 1);
      ign_start = 1'b0;
      drive();
      step();
      chk("busy_after_done", mb_busy, 1'b0);
   endtask

   initial begin
      int cyc;
      int done0;
      reset = 1'b1;
      mb_start = 1'b0;
      bus.dp_src_ready = 1'b0;
      bus.dp_dst_valid = 1'b0;
      bus.out_ready = 1'b0;
      step();
      checking = 1'b1;
      step();
      reset = 1'b0;
      chk("rst_busy", mb_busy, 1'b0);
      chk("rst_done", mb_done, 1'b0);
      chk("rst_err", err, 1'b0);
      chk("rst_src_valid", bus.dp_src_valid, 1'b0);
      chk("rst_out_valid", bus.out_valid, 1'b0);
      chk("rst_blk", {bus.blk_y, bus.blk_x}, 0);
      step();

      // full macroblock, everything ready
      p_src = 100; p_dst = 100; p_out = 100;
      run_mb(-1, 400);

      // downstream stalls for 20 cycles mid-run
      run_mb(4, 400);

      // mb_start held through RUN and DONE must not launch a second run
      p_src = 70; p_dst = 60; p_out = 70;
      ign_start = 1'b1;
      run_mb(-1, 400);
      drive(); step();
      chk("no_second_run", mb_busy, 1'b0);

      // abort after 5 issues and 3 returns
      done0 = done_seen;
      drive();
      mb_start = 1'b1;
      step();
      cyc = 0;
      while (!(n_iss == 5 && n_ret == 3) && cyc < 100) begin
         mb_start = 1'b0;
         bus.dp_src_ready = (n_iss < 5);
         bus.out_ready = 1'b1;
         bus.dp_dst_valid = (q_blk.size() > 0) && (n_ret < 3);
         step();
         cyc++;
      end
      chk("abort_setup_timeout", cyc < 100, 1'b1);
      reset = 1'b1;
      bus.dp_dst_valid = 1'b0;
      bus.dp_src_ready = 1'b0;
      step();
      reset = 1'b0;
      chk("abort_busy", mb_busy, 1'b0);
      chk("abort_src_valid", bus.dp_src_valid, 1'b0);
      chk("abort_idx", bus.out_blk_idx, 0);
      step();
      chk("abort_no_done", done_seen - done0, 0);
      p_src = 100; p_dst = 100; p_out = 100;
      run_mb(-1, 400);

      // spurious return in IDLE
      bus.dp_src_ready = 1'b0;
      bus.out_ready = 1'b1;
      bus.dp_dst_valid = 1'b1;
      mb_start = 1'b0;
      step();
      drive();
      step();
      chk("err_set", err, 1'b1);
      p_src = 60; p_dst = 50; p_out = 60;
      run_mb(-1, 500);
      chk("err_sticky", err, 1'b1);

      // a few more random macroblocks with a fresh error state
      reset = 1'b1;
      drive();
      step();
      reset = 1'b0;
      for (int r = 0; r < 3; r++) begin
         p_src = int'($urandom_range(90, 30));
         p_dst = int'($urandom_range(90, 30));
         p_out = int'($urandom_range(90, 30));
         run_mb((r == 1) ? 6 : -1, 600);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog no completion t=%0t", $time);
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/mc_lc_ctrl.md
# mc_lc_ctrl

Sequencing controller for the `mc_lc` motion-compensation residual datapath. It accepts one macroblock-level start request and walks the macroblock's 4x4 sub-blocks through `mc_lc` in raster order. It drives the sub-block coordinates for the reference/current fetch, bounds the number of sub-blocks in flight, and forwards residual beats downstream with backpressure. It pulses completion when the last residual of the macroblock has been accepted.

## Interface

Parameters:
- `MB_SIZE`, 4: sub-block edge in pixels; informational, matches `mc_lc`.
- `BLKS_X`, 4: sub-blocks per macroblock row; power of two.
- `BLKS_Y`, 4: sub-block rows per macroblock; power of two.
- `MAX_INFLIGHT`, 2: maximum sub-blocks issued to `mc_lc` but not yet returned; range 1..`BLKS_X*BLKS_Y`.

Derived widths:
- `NBLK = BLKS_X*BLKS_Y`.
- `XW = $clog2(BLKS_X)`, `YW = $clog2(BLKS_Y)`.
- `IW = $clog2(NBLK)`.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `mb_start` in 1: request to process one macroblock; sampled only in IDLE.
- `mb_busy` out 1: high in every state except IDLE.
- `mb_done` out 1: one-cycle pulse in DONE.
- `blk_x` out XW: column of the sub-block currently offered to `mc_lc`.
- `blk_y` out YW: row of the sub-block currently offered to `mc_lc`.
- `dp_src_valid` out 1: drives `mc_lc.src_valid`.
- `dp_src_ready` in 1: from `mc_lc.src_ready`.
- `dp_dst_valid` in 1: from `mc_lc.dst_valid`.
- `dp_dst_ready` out 1: drives `mc_lc.dst_ready`.
- `out_valid` out 1: residual beat valid to downstream (transform stage).
- `out_ready` in 1: downstream accept.
- `out_blk_idx` out IW: raster index of the residual beat on `out_valid`.
- `err` out 1: sticky protocol error.

## Operation

States: IDLE, RUN, DONE.

Counters:
- `iss_cnt` (0..NBLK) counts issue handshakes, where issue = `dp_src_valid && dp_src_ready`.
- `ret_cnt` (0..NBLK) counts return handshakes, where return = `dp_dst_valid && dp_dst_ready`.
- `inflight = iss_cnt - ret_cnt`.

IDLE:
- Both counters are 0.
- `mb_start=1` moves to RUN next cycle.
- `dp_src_valid`, `dp_dst_ready`, `out_valid` are all 0.

RUN:
- `dp_src_valid = (iss_cnt < NBLK) && (inflight < MAX_INFLIGHT)`.
- `blk_x = iss_cnt % BLKS_X`, `blk_y = iss_cnt / BLKS_X`. The coordinates hold stable while `dp_src_valid` is high and not yet accepted.
- `dp_dst_ready = out_ready` (combinational pass-through).
- `out_valid = dp_dst_valid`.
- `out_blk_idx = ret_cnt[IW-1:0]`.
- Counters increment on their handshakes. Issue and return in the same cycle both increment, so `inflight` is unchanged.
- When the return handshake happens with `ret_cnt == NBLK-1`, the next state is DONE.

DONE:
- Lasts exactly one cycle with `mb_done=1`, then returns to IDLE.
- Counters clear to 0 on entry to IDLE.

Other rules:
- `mb_start` is ignored in RUN and DONE; it is not queued.
- `err` is set when `dp_dst_valid=1` while `inflight==0` (this includes IDLE and DONE). It holds until `reset`. The spurious beat is not forwarded (`out_valid=0`) and not counted.
- `blk_x`/`blk_y` read 0 outside RUN.

## Timing

- Reset: the cycle after `reset` is sampled high, state is IDLE, counters are 0, and all outputs are 0 (`mb_busy`, `mb_done`, `dp_src_valid`, `dp_dst_ready`, `out_valid`, `out_blk_idx`, `blk_x`, `blk_y`, `err`).
- Reset mid-operation aborts the macroblock; no `mb_done` is produced.
- Start latency: `mb_start` sampled at edge T gives RUN with `dp_src_valid=1` and `blk=(0,0)` during cycle T+1.
- `dp_src_valid` and `blk_x`/`blk_y` depend only on registered state, with no combinational path from any input.
- The only combinational paths are `out_ready → dp_dst_ready` and `dp_dst_valid → out_valid`.
- Issue throughput: one sub-block per cycle while `dp_src_ready=1` and the in-flight limit is not reached.
- When `inflight == MAX_INFLIGHT`, `dp_src_valid` drops the cycle after the limiting issue. It rises again the cycle after a return handshake.
- Completion: last return handshake at edge N gives `mb_done=1` in cycle N+1 and IDLE in cycle N+2. A new `mb_start` is accepted at edge N+2 at the earliest.

## Test plan

- Reset: hold `reset` 2 cycles → all outputs 0; `mb_busy=0`.
- Full macroblock, `mc_lc` and `out_ready` always ready:
  - `mb_start` pulse → `blk` sequence (0,0),(1,0),(2,0),(3,0),(0,1)…(3,3), 16 issues.
  - 16 `out_valid` beats with `out_blk_idx` 0..15 in order.
  - `mb_done` high exactly 1 cycle; `mb_busy` low the cycle after.
- Backpressure:
  - `out_ready=0` for 20 cycles mid-run → `inflight` caps at 2 and `dp_src_valid=0`.
  - Release → indices resume without gap or duplicate; 16 total beats.
- Ignored start: `mb_start` pulsed in RUN and in the DONE cycle → no second run; exactly one `mb_done`.
- Reset mid-MB after 5 issues and 3 returns → next cycle all outputs 0. New `mb_start` restarts at `blk=(0,0)`, `out_blk_idx=0`, with no `mb_done` for the aborted macroblock.
- Spurious return: `dp_dst_valid=1` in IDLE → `err=1` next cycle and stays 1 through a following full macroblock; `out_valid` stays 0 for the spurious beat.
